// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic master: host valid/ready requests in, one response out,
// with misalignment/timeout error reporting and core_select arbitration toward the memory top.
module wb_host_master #(
    parameter int ADDRESS_LENGTH = 32,
    parameter int DATA_LENGTH    = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDRESS_LENGTH-1:0] req_addr,
    input  logic [DATA_LENGTH-1:0]    req_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_LENGTH-1:0]    rsp_data,
    output logic                      rsp_err,
    output logic [ADDRESS_LENGTH-1:0] ADR_O,
    output logic [DATA_LENGTH-1:0]    DAT_O,
    input  logic [DATA_LENGTH-1:0]    DAT_I,
    output logic                      we,
    output logic                      stb,
    output logic                      cyc,
    input  logic                      ack,
    input  logic                      run_en,
    output logic                      core_select
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;

    // Transaction FSM; every host and bus output is a register updated here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            ADR_O       <= '0;
            DAT_O       <= '0;
            we          <= 1'b0;
            stb         <= 1'b0;
            cyc         <= 1'b0;
            core_select <= 1'b0;
        end else begin
            // Uses the current state, so it trails the FSM by one cycle in both directions.
            core_select <= run_en & (state_r == IDLE) & ~req_valid;
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        ADR_O     <= req_addr;
                        DAT_O     <= req_data;
                        we        <= req_we;
                        if (req_addr[1:0] == 2'b00) begin
                            cyc     <= 1'b1;
                            stb     <= 1'b1;
                            cnt_r   <= '0;
                            state_r <= BUS;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state_r   <= RESP;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                BUS: begin
                    // An ack in the final counted cycle still completes the transfer normally.
                    if (ack) begin
                        cyc       <= 1'b0;
                        stb       <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= we ? '0 : DAT_I;
                        state_r   <= RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        cyc       <= 1'b0;
                        stb       <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state_r   <= RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        req_ready <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    cyc       <= 1'b0;
                    stb       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_host_master.sv
// Randomized bench for wb_host_master: in-bench slave plus a transaction-level model predicting
// response data, error, latency and bus-phase length for each request.
module tb_wb_host_master;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data, ADR_O, DAT_O, DAT_I;
    logic        we, stb, cyc, ack, run_en, core_select;

    int tests_run = 0;
    int failed    = 0;

    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    wb_host_master #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
        .we(we), .stb(stb), .cyc(cyc), .ack(ack),
        .run_en(run_en), .core_select(core_select)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_data = 32'h0;
        rsp_ready = 1'b0; DAT_I = 32'h0; ack = 1'b0; run_en = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (req_ready !== 1'b0) begin failed++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        tests_run++; if ({rsp_valid, rsp_err, cyc, stb, we, core_select} !== 6'b0) begin failed++; $display("FAIL rst_ctrl got=%b exp=000000", {rsp_valid, rsp_err, cyc, stb, we, core_select}); end
        tests_run++; if ({rsp_data, ADR_O, DAT_O} !== 96'h0) begin failed++; $display("FAIL rst_buses got=%h exp=0", {rsp_data, ADR_O, DAT_O}); end
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if (req_ready !== 1'b1) begin failed++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
    endtask

    // One full request/response; expectations come from the transaction-level rules.
    task automatic transact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input int dly, input int hold);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat, exp_cyc, lat, ncyc;
        logic        seen;
        if (a[1:0] != 2'b00) begin
            exp_err = 1'b1; exp_data = 32'h0; exp_lat = 1; exp_cyc = 0;
        end else if (dly >= 0 && dly + 1 <= T) begin
            exp_err = 1'b0; exp_cyc = dly + 1; exp_lat = dly + 2;
            exp_data = w ? 32'h0 : (ref_mem.exists(a) ? ref_mem[a] : ~a);
            if (w) ref_mem[a] = d;
        end else begin
            exp_err = 1'b1; exp_data = 32'h0; exp_cyc = T; exp_lat = T + 1;
        end

        @(negedge clk);
        tests_run++; if (req_ready !== 1'b1) begin failed++; $display("FAIL start_ready got=%b exp=1", req_ready); end
        tests_run++; if (core_select !== 1'b1) begin failed++; $display("FAIL start_core_select got=%b exp=1", core_select); end
        req_valid = 1'b1; req_we = w; req_addr = a; req_data = d;
        @(negedge clk);
        req_valid = 1'b0; req_we = ~w; req_addr = $urandom; req_data = $urandom;
        lat = 1; ncyc = 0; seen = 1'b0;
        while (lat <= 64) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            tests_run++; if ({core_select, req_ready} !== 2'b00) begin failed++; $display("FAIL busy_flags core_select/req_ready got=%b exp=00", {core_select, req_ready}); end
            if (cyc) begin
                ncyc++;
                tests_run++; if ({stb, we, ADR_O, DAT_O} !== {1'b1, w, a, d}) begin failed++; $display("FAIL bus_hold got=%b/%b/%h/%h exp=1/%b/%h/%h", stb, we, ADR_O, DAT_O, w, a, d); end
                if (ncyc == dly + 1) begin
                    ack = 1'b1;
                    if (we) begin
                        slave_mem[ADR_O] = DAT_O;
                        DAT_I = $urandom;
                    end else begin
                        DAT_I = slave_mem.exists(ADR_O) ? slave_mem[ADR_O] : ~ADR_O;
                    end
                end else begin
                    ack = 1'b0; DAT_I = $urandom;
                end
            end else begin
                ack = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        ack = 1'b0;
        tests_run++; if (seen !== 1'b1) begin failed++; $display("FAIL rsp_timeout no rsp_valid within 64 cycles exp=1"); end
        tests_run++; if (lat != exp_lat) begin failed++; $display("FAIL rsp_latency got=%0d exp=%0d", lat, exp_lat); end
        tests_run++; if (ncyc != exp_cyc) begin failed++; $display("FAIL cyc_cycles got=%0d exp=%0d", ncyc, exp_cyc); end
        tests_run++; if ({rsp_err, rsp_data} !== {exp_err, exp_data}) begin failed++; $display("FAIL rsp err/data got=%b/%h exp=%b/%h", rsp_err, rsp_data, exp_err, exp_data); end
        tests_run++; if ({cyc, stb, req_ready} !== 3'b000) begin failed++; $display("FAIL resp_idle_bus got=%b exp=000", {cyc, stb, req_ready}); end

        // Host stalls with a competing request and stray acks; nothing may change.
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_addr = 32'h40; req_we = 1'b0;
            ack = 1'($urandom_range(0, 1)); DAT_I = $urandom;
            @(negedge clk);
            tests_run++; if ({rsp_valid, rsp_err, rsp_data, req_ready, cyc} !== {1'b1, exp_err, exp_data, 1'b0, 1'b0}) begin failed++; $display("FAIL stall_hold got=%b/%b/%h/%b/%b exp=1/%b/%h/0/0", rsp_valid, rsp_err, rsp_data, req_ready, cyc, exp_err, exp_data); end
        end
        req_valid = 1'b0; ack = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests_run++; if ({rsp_valid, req_ready, core_select} !== 3'b010) begin failed++; $display("FAIL after_rsp valid/ready/core_select got=%b exp=010", {rsp_valid, req_ready, core_select}); end
        @(negedge clk);
        tests_run++; if (core_select !== 1'b1) begin failed++; $display("FAIL core_select_return got=%b exp=1", core_select); end
    endtask

    task automatic test_write_read();
        transact(1'b1, 32'h10, 32'hDEADBEEF, 1, 0);
        transact(1'b0, 32'h10, 32'h0, 2, 0);
        transact(1'b0, 32'h24, 32'h0, 0, 1);
    endtask

    task automatic test_misaligned();
        transact(1'b1, 32'h13, 32'h12345678, 0, 0);
        transact(1'b0, 32'h11, 32'h0, 0, 2);
    endtask

    task automatic test_timeout();
        transact(1'b0, 32'h30, 32'h0, -1, 0);
        transact(1'b1, 32'h34, 32'hCAFEF00D, T - 1, 0);
        transact(1'b0, 32'h34, 32'h0, T, 0);
    endtask

    task automatic test_stall();
        transact(1'b0, 32'h10, 32'h0, 3, 5);
    endtask

    task automatic test_core_select();
        run_en = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (core_select !== 1'b0) begin failed++; $display("FAIL core_select_run_en_low got=%b exp=0", core_select); end
        run_en = 1'b1;
        @(negedge clk);
        tests_run++; if (core_select !== 1'b1) begin failed++; $display("FAIL core_select_run_en_high got=%b exp=1", core_select); end
    endtask

    task automatic test_reset_mid_bus();
        int stray;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (cyc !== 1'b1) begin failed++; $display("FAIL mid_bus_cyc got=%b exp=1", cyc); end
        #2 reset = 1'b0;
        #1;
        tests_run++; if ({cyc, stb, rsp_valid, req_ready, we, core_select} !== 6'b0) begin failed++; $display("FAIL async_reset_ctrl got=%b exp=000000", {cyc, stb, rsp_valid, req_ready, we, core_select}); end
        tests_run++; if (ADR_O !== 32'h0) begin failed++; $display("FAIL async_reset_adr got=%h exp=0", ADR_O); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++; if ({req_ready, rsp_valid, cyc} !== 3'b100) begin failed++; $display("FAIL post_reset got=%b exp=100", {req_ready, rsp_valid, cyc}); end
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || cyc) stray++;
        end
        tests_run++; if (stray != 0) begin failed++; $display("FAIL stale_response got=%0d cycles exp=0", stray); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          dly, r;
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            r = $urandom_range(0, 9);
            dly = (r == 0) ? -1 : (r == 1) ? T - 1 : $urandom_range(0, 5);
            transact(1'($urandom_range(0, 1)), a, $urandom, dly, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_core_select();
        test_write_read();
        test_misaligned();
        test_timeout();
        test_stall();
        test_reset_mid_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
